// File: rtl/tdm_demux18.sv
// Receive end of an 8:1 TDM serial link: rebuilds eight slot bits into a..h.
// Slot k of a frame lands on output (h,g,f,e,d,c,b,a)[k]; frame_start marks slot 0.
module tdm_demux18 #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TO_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    input  logic       din_valid,
    input  logic       frame_start,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g,
    output logic       h,
    output logic [2:0] s,
    output logic       frame_valid,
    output logic       sync_err
);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t          state, state_nx;
    logic [7:0]      shadow, shadow_nx;
    logic [2:0]      slot, slot_nx;
    logic [TO_W-1:0] idle_cnt, idle_cnt_nx;
    logic [7:0]      frame_q, frame_nx;   // bit k holds slot k of the last complete frame
    logic            fv_q, fv_nx;
    logic            se_q, se_nx;

    // Next-state, slot bookkeeping and output-register load decisions
    always_comb begin
        state_nx    = state;
        shadow_nx   = shadow;
        slot_nx     = slot;
        idle_cnt_nx = idle_cnt;
        frame_nx    = frame_q;
        fv_nx       = 1'b0;
        se_nx       = 1'b0;
        case (state)
            IDLE: begin
                if (din_valid) begin
                    if (frame_start) begin
                        shadow_nx    = '0;
                        shadow_nx[0] = din;
                        slot_nx      = 3'd1;
                        idle_cnt_nx  = '0;
                        state_nx     = COLLECT;
                    end else begin
                        se_nx = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (din_valid) begin
                    idle_cnt_nx = '0;
                    if (frame_start) begin
                        shadow_nx    = '0;
                        shadow_nx[0] = din;
                        slot_nx      = 3'd1;
                        se_nx        = 1'b1;
                    end else if (slot == 3'd7) begin
                        // The eighth bit goes straight into the output register
                        frame_nx = {din, shadow[6:0]};
                        fv_nx    = 1'b1;
                        slot_nx  = '0;
                        state_nx = IDLE;
                    end else begin
                        shadow_nx[slot] = din;
                        slot_nx         = slot + 3'd1;
                    end
                end else begin
                    // Comparing against TIMEOUT-1 makes the TIMEOUT-th idle cycle abort
                    if (idle_cnt == TO_W'(TIMEOUT - 1)) begin
                        idle_cnt_nx = '0;
                        slot_nx     = '0;
                        se_nx       = 1'b1;
                        state_nx    = IDLE;
                    end else begin
                        idle_cnt_nx = idle_cnt + TO_W'(1);
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                slot_nx  = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            shadow   <= '0;
            slot     <= '0;
            idle_cnt <= '0;
            frame_q  <= '0;
            fv_q     <= 1'b0;
            se_q     <= 1'b0;
        end else begin
            state    <= state_nx;
            shadow   <= shadow_nx;
            slot     <= slot_nx;
            idle_cnt <= idle_cnt_nx;
            frame_q  <= frame_nx;
            fv_q     <= fv_nx;
            se_q     <= se_nx;
        end
    end

    assign h           = frame_q[0];
    assign g           = frame_q[1];
    assign f           = frame_q[2];
    assign e           = frame_q[3];
    assign d           = frame_q[4];
    assign c           = frame_q[5];
    assign b           = frame_q[6];
    assign a           = frame_q[7];
    assign s           = slot;
    assign frame_valid = fv_q;
    assign sync_err    = se_q;

endmodule
